// File: rtl/pdua_display_driver.sv
// Multiplexed common-anode 7-segment driver for the PDUA byte-pair output.
// Hex display by default; define PDUA_DISP_BCD_EN for decimal display via double dabble.
module pdua_display_driver #(
   parameter int unsigned REFRESH_DIV = 50000,
   parameter int unsigned NDIG        = 6
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            strobe_i,
   input  logic [7:0]      data_hi_i,
   input  logic [7:0]      data_lo_i,
   output logic [6:0]      seg_n,
   output logic            dp_n,
   output logic [NDIG-1:0] an_n,
   output logic            busy
);

`ifdef PDUA_DISP_BCD_EN
   localparam int unsigned NUsed = 6;
   localparam int unsigned DispW = 24;
   localparam logic [2:0]  DpDig = 3'd3;
`else
   localparam int unsigned NUsed = 4;
   localparam int unsigned DispW = 16;
   localparam logic [2:0]  DpDig = 3'd2;
`endif
   localparam int unsigned   PW     = $clog2(REFRESH_DIV);
   localparam logic [PW-1:0] PreMax = PW'(REFRESH_DIV - 1);
   localparam logic [2:0]    IdxMax = 3'(NUsed - 1);

   function automatic logic [6:0] hex_font(input logic [3:0] v);
      logic [6:0] s;
      case (v)
         4'h0: s = 7'h40;
         4'h1: s = 7'h79;
         4'h2: s = 7'h24;
         4'h3: s = 7'h30;
         4'h4: s = 7'h19;
         4'h5: s = 7'h12;
         4'h6: s = 7'h02;
         4'h7: s = 7'h78;
         4'h8: s = 7'h00;
         4'h9: s = 7'h10;
         4'hA: s = 7'h08;
         4'hB: s = 7'h03;
         4'hC: s = 7'h46;
         4'hD: s = 7'h21;
         4'hE: s = 7'h06;
         default: s = 7'h0E;
      endcase
      return s;
   endfunction

   logic             strobe_q;
   logic             cap;
   logic [PW-1:0]    presc_q, presc_d;
   logic [2:0]       idx_q, idx_d;
   logic [DispW-1:0] disp_q, disp_d;
   logic [6:0]       seg_q, seg_d;
   logic             dp_q, dp_d;
   logic [NDIG-1:0]  an_q, an_d;
   logic             wrap;
   logic [3:0]       cur_dig;

   assign cap  = strobe_i & ~strobe_q;
   assign wrap = (presc_q == PreMax);

   always_comb begin
      cur_dig = 4'h0;
      case (idx_q)
         3'd0: cur_dig = disp_q[3:0];
         3'd1: cur_dig = disp_q[7:4];
         3'd2: cur_dig = disp_q[11:8];
         3'd3: cur_dig = disp_q[15:12];
`ifdef PDUA_DISP_BCD_EN
         3'd4: cur_dig = disp_q[19:16];
         3'd5: cur_dig = disp_q[23:20];
`endif
         default: cur_dig = 4'h0;
      endcase
   end

   // Outputs reflect the digit selected by idx_q and only change on a prescaler wrap.
   always_comb begin
      presc_d = presc_q + 1'b1;
      idx_d   = idx_q;
      seg_d   = seg_q;
      dp_d    = dp_q;
      an_d    = an_q;
      if (wrap) begin
         presc_d = '0;
         idx_d   = (idx_q == IdxMax) ? 3'd0 : idx_q + 3'd1;
         seg_d   = hex_font(cur_dig);
         dp_d    = (idx_q != DpDig);
         an_d    = ~({{(NDIG-1){1'b0}}, 1'b1} << idx_q);
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         strobe_q <= 1'b0;
         presc_q  <= '0;
         idx_q    <= '0;
         disp_q   <= '0;
         seg_q    <= 7'h7F;
         dp_q     <= 1'b1;
         an_q     <= '1;
      end else begin
         strobe_q <= strobe_i;
         presc_q  <= presc_d;
         idx_q    <= idx_d;
         disp_q   <= disp_d;
         seg_q    <= seg_d;
         dp_q     <= dp_d;
         an_q     <= an_d;
      end
   end

   assign seg_n = seg_q;
   assign dp_n  = dp_q;
   assign an_n  = an_q;

`ifdef PDUA_DISP_BCD_EN
   typedef enum logic {StIdle, StConv} conv_st_e;

   // One add-3-then-shift step on {bcd[11:0], bin[7:0]}.
   function automatic logic [19:0] dd_step(input logic [19:0] s);
      logic [19:0] t;
      t = s;
      for (int i = 0; i < 3; i++) begin
         if (t[8+4*i +: 4] >= 4'd5) t[8+4*i +: 4] = t[8+4*i +: 4] + 4'd3;
      end
      return {t[18:0], 1'b0};
   endfunction

   conv_st_e    st_q, st_d;
   logic [19:0] sh_hi_q, sh_hi_d, sh_lo_q, sh_lo_d;
   logic [19:0] nx_hi, nx_lo;
   logic [7:0]  shd_hi_q, shd_hi_d, shd_lo_q, shd_lo_d;
   logic        pend_q, pend_d;
   logic [2:0]  step_q, step_d;

   assign nx_hi = dd_step(sh_hi_q);
   assign nx_lo = dd_step(sh_lo_q);

   always_comb begin
      st_d     = st_q;
      sh_hi_d  = sh_hi_q;
      sh_lo_d  = sh_lo_q;
      shd_hi_d = shd_hi_q;
      shd_lo_d = shd_lo_q;
      pend_d   = pend_q;
      step_d   = step_q;
      disp_d   = disp_q;
      unique case (st_q)
         StIdle: begin
            if (cap || pend_q) begin
               sh_hi_d = cap ? {12'd0, data_hi_i} : {12'd0, shd_hi_q};
               sh_lo_d = cap ? {12'd0, data_lo_i} : {12'd0, shd_lo_q};
               pend_d  = 1'b0;
               step_d  = 3'd0;
               st_d    = StConv;
            end
         end
         StConv: begin
            sh_hi_d = nx_hi;
            sh_lo_d = nx_lo;
            step_d  = step_q + 3'd1;
            // Newest bytes overwrite any earlier queued pair.
            if (cap) begin
               shd_hi_d = data_hi_i;
               shd_lo_d = data_lo_i;
               pend_d   = 1'b1;
            end
            if (step_q == 3'd7) begin
               disp_d = {nx_hi[19:8], nx_lo[19:8]};
               st_d   = StIdle;
            end
         end
         default: st_d = StIdle;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         st_q     <= StIdle;
         sh_hi_q  <= '0;
         sh_lo_q  <= '0;
         shd_hi_q <= '0;
         shd_lo_q <= '0;
         pend_q   <= 1'b0;
         step_q   <= '0;
      end else begin
         st_q     <= st_d;
         sh_hi_q  <= sh_hi_d;
         sh_lo_q  <= sh_lo_d;
         shd_hi_q <= shd_hi_d;
         shd_lo_q <= shd_lo_d;
         pend_q   <= pend_d;
         step_q   <= step_d;
      end
   end

   assign busy = (st_q == StConv);
`else
   assign disp_d = cap ? {data_hi_i, data_lo_i} : disp_q;
   assign busy   = 1'b0;
`endif

endmodule

// File: tb/tb_pdua_display_driver.sv
// Randomized self-checking bench for pdua_display_driver against a behavioural display model.
// Honours PDUA_DISP_BCD_EN the same way the design does.
module tb_pdua_display_driver;

   localparam int RD = 4;
`ifdef PDUA_DISP_BCD_EN
   localparam int NUSED  = 6;
   localparam int DP_DIG = 3;
`else
   localparam int NUSED  = 4;
   localparam int DP_DIG = 2;
`endif

   logic       clk;
   logic       rst;
   logic       strobe_i;
   logic [7:0] data_hi_i;
   logic [7:0] data_lo_i;
   logic [6:0] seg_n;
   logic       dp_n;
   logic [5:0] an_n;
   logic       busy;

   pdua_display_driver #(
      .REFRESH_DIV(RD),
      .NDIG       (6)
   ) dut (
      .clk      (clk),
      .rst      (rst),
      .strobe_i (strobe_i),
      .data_hi_i(data_hi_i),
      .data_lo_i(data_lo_i),
      .seg_n    (seg_n),
      .dp_n     (dp_n),
      .an_n     (an_n),
      .busy     (busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   logic [6:0] font [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                             7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

   int n_cmp = 0;
   int n_bad = 0;

   // Model state: displayed binary bytes, scan timing, conversion queue.
   logic       m_sprev;
   int         m_n;
   int         m_wraps;
   logic [7:0] m_dhi, m_dlo;
   logic       m_busy;
   int         m_left;
   logic [7:0] m_chi, m_clo;
   logic       m_pend;
   logic [7:0] m_phi, m_plo;
   logic [6:0] e_seg;
   logic [5:0] e_an;
   logic       e_dp;

   task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
      end
   endtask

   function automatic int digit_of(input int d);
`ifdef PDUA_DISP_BCD_EN
      int v;
      v = (d < 3) ? int'(m_dlo) : int'(m_dhi);
      for (int k = 0; k < d % 3; k++) v = v / 10;
      return v % 10;
`else
      return (int'({m_dhi, m_dlo}) >> (4 * d)) & 15;
`endif
   endfunction

   task automatic model_reset();
      m_sprev = 1'b0;
      m_n     = 0;
      m_wraps = 0;
      m_dhi   = 8'h00;
      m_dlo   = 8'h00;
      m_busy  = 1'b0;
      m_left  = 0;
      m_chi   = 8'h00;
      m_clo   = 8'h00;
      m_pend  = 1'b0;
      m_phi   = 8'h00;
      m_plo   = 8'h00;
      e_seg   = 7'h7F;
      e_an    = 6'h3F;
      e_dp    = 1'b1;
   endtask

   task automatic model_edge(input logic s, input logic [7:0] hi, input logic [7:0] lo);
      logic cap;
      int   d;
      cap     = s && !m_sprev;
      m_sprev = s;
      m_n++;
      if (m_n % RD == 0) begin
         d       = m_wraps % NUSED;
         m_wraps++;
         e_an    = 6'h3F;
         e_an[d] = 1'b0;
         e_seg   = font[4'(digit_of(d))];
         e_dp    = (d == DP_DIG) ? 1'b0 : 1'b1;
      end
`ifdef PDUA_DISP_BCD_EN
      if (m_busy) begin
         if (cap) begin
            m_pend = 1'b1;
            m_phi  = hi;
            m_plo  = lo;
         end
         m_left--;
         if (m_left == 0) begin
            m_busy = 1'b0;
            m_dhi  = m_chi;
            m_dlo  = m_clo;
         end
      end else if (cap || m_pend) begin
         m_busy = 1'b1;
         m_left = 8;
         m_chi  = cap ? hi : m_phi;
         m_clo  = cap ? lo : m_plo;
         m_pend = 1'b0;
      end
`else
      if (cap) begin
         m_dhi = hi;
         m_dlo = lo;
      end
`endif
   endtask

   task automatic step(input logic s, input logic [7:0] hi, input logic [7:0] lo);
      strobe_i  = s;
      data_hi_i = hi;
      data_lo_i = lo;
      @(posedge clk);
      model_edge(s, hi, lo);
      #1;
      check_val("seg_n", 32'(seg_n), 32'(e_seg));
      check_val("an_n", 32'(an_n), 32'(e_an));
      check_val("dp_n", 32'(dp_n), 32'(e_dp));
      check_val("busy", 32'(busy), 32'(m_busy));
      if (an_n != 6'h3F) check_val("an_onehot", 32'($countones(~an_n)), 32'd1);
      #3;
   endtask

   // Asserted between clock edges; outputs must blank before any edge arrives.
   task automatic do_reset();
      rst = 1'b1;
      #1;
      check_val("rst_seg", 32'(seg_n), 32'h7F);
      check_val("rst_an", 32'(an_n), 32'h3F);
      check_val("rst_dp", 32'(dp_n), 32'h1);
      check_val("rst_busy", 32'(busy), 32'h0);
      model_reset();
      @(posedge clk);
      @(posedge clk);
      #4;
      rst = 1'b0;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) step(1'b0, 8'($urandom), 8'($urandom));
   endtask

   initial begin
      int         gap, hold;
      logic [7:0] rh, rl;
      rst       = 1'b0;
      strobe_i  = 1'b0;
      data_hi_i = 8'h00;
      data_lo_i = 8'h00;
      #2;
      do_reset();

      // Blank until the first wrap, then a full frame of zeros.
      idle(2 * RD * NUSED);

      step(1'b1, 8'hA5, 8'h3C);
      idle(3 * RD * NUSED);

      // Held strobe: only the first byte pair is captured.
      step(1'b1, 8'h00, 8'h01);
      for (int i = 0; i < 9; i++) step(1'b1, 8'h00, 8'h02);
      idle(20 * RD);

`ifdef PDUA_DISP_BCD_EN
      step(1'b1, 8'd255, 8'd7);
      idle(RD * NUSED * 2);
      // Overlapping captures: latest queued pair wins.
      step(1'b1, 8'd1, 8'd2);
      idle(2);
      step(1'b1, 8'd10, 8'd3);
      step(1'b0, 8'd0, 8'd0);
      step(1'b1, 8'd99, 8'd4);
      idle(30 + RD * NUSED);
      step(1'b1, 8'd123, 8'd45);
      idle(4);
      do_reset();
      idle(RD * NUSED);
`endif

      for (int it = 0; it < 150; it++) begin
         gap  = int'($urandom_range(0, 12));
         hold = int'($urandom_range(1, 4));
         idle(gap);
         rh = 8'($urandom);
         rl = 8'($urandom);
         step(1'b1, rh, rl);
         for (int h = 1; h < hold; h++) step(1'b1, 8'($urandom), 8'($urandom));
         if (it == 75) do_reset();
      end
      idle(3 * RD * NUSED);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/pdua_display_driver.md
Name: pdua_display_driver

Overview:
- Output stage directly downstream of the PDUA core; consumes its 1-bit strobe output and its two 8-bit data outputs.
- Captures the byte pair on a strobe rising edge and holds it for display.
- Drives a multiplexed, active-low common-anode 7-segment display using time-division digit scanning.
- Hex display by default; optional decimal (BCD) display uses a sequential double-dabble converter.

Parameters:
- REFRESH_DIV, 50000: clk cycles per digit slot; the prescaler counts 0..REFRESH_DIV-1. Legal range ≥2.
- NDIG, 6: number of anode lines. Fixed at 6; in hex mode only digits 0..3 are used.

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  reset, asynchronous, active-high
- strobe_i  in  1  display-write strobe from PDUA out_d1
- data_hi_i  in  8  high byte from PDUA out_d2
- data_lo_i  in  8  low byte from PDUA out_d3
- seg_n  out  7  segments g..a on bits 6..0, active-low
- dp_n  out  1  decimal point, active-low
- an_n  out  6  digit anodes, active-low, one-hot
- busy  out  1  BCD conversion in progress

Behaviour:
- Interface: one clock; reset is asynchronous and active-high, ports clk and rst.
- Reset values:
  - seg_n=7'h7F, dp_n=1, an_n=6'h3F, busy=0.
  - Shadow/display registers=0, prescaler=0, digit index=0, strobe_q=0, pending=0.
- Edge detect:
  - strobe_q registers strobe_i.
  - A capture event occurs when strobe_i=1 and strobe_q=0.
  - Holding strobe_i high produces exactly one capture.
- Hex mode, on a capture event:
  - At that clk edge, the display registers load {data_hi_i, data_lo_i}. Latency is 1 edge; busy stays 0.
  - Digit mapping: digit0 = lo[3:0], digit1 = lo[7:4], digit2 = hi[3:0], digit3 = hi[7:4].
  - Digits 4 and 5 stay dark: an_n bit high and never selected.
- Scan:
  - The prescaler wraps at REFRESH_DIV-1. On each wrap, the digit index advances 0→1→…→NUSED-1→0, where NUSED=4 in hex mode and 6 in BCD mode.
  - All outputs are registered and update on the wrap edge.
  - an_n stays all-ones until the first wrap after reset; on that wrap an_n[0]=0.
  - Only one an_n bit is low at any time.
- Segment table: standard hex font, active-low.
  - 0=7'h40, 1=7'h79, 2=7'h24, 3=7'h30, 4=7'h19, 5=7'h12, 6=7'h02, 7=7'h78
  - 8=7'h00, 9=7'h10, A=7'h08, b=7'h03, C=7'h46, d=7'h21, E=7'h06, F=7'h0E
- Decimal point: dp_n=0 only while digit 2 is active in hex mode (byte separator), or digit 3 in BCD mode; otherwise dp_n=1.
- A capture does not disturb the scan position or the prescaler.
- Reset mid-scan: all outputs return to reset values immediately, without waiting for a clk edge.

Optional Feature:
- Macro: PDUA_DISP_BCD_EN.
- Undefined: hex mode as above; busy is tied 0.
- Defined: BCD mode.
  - On a capture event, both bytes load into shift registers and busy goes to 1.
  - The next 8 clk edges each perform one add-3-then-shift step on both bytes in parallel (3 BCD digits per byte).
  - On the 8th step, the display registers load atomically and busy drops to 0, so busy is high for exactly 8 cycles.
  - Digit mapping: digits 0..2 = lo units/tens/hundreds; digits 3..5 = hi units/tens/hundreds.
  - A capture event while busy sets pending and overwrites the shadow with the newest bytes. One-deep queue: latest data wins.
  - If pending is set at completion, the next conversion starts on the following edge.
  - Reset mid-conversion: busy=0, pending=0, and the display stays blank.

Test Plan:
- Reset: assert rst asynchronously between clk edges -> seg_n=7'h7F, an_n=6'h3F, dp_n=1, busy=0 immediately.
- Hex capture: REFRESH_DIV=4; strobe pulse with hi=8'hA5, lo=8'h3C -> scanned digit0..3 show seg_n 7'h46, 7'h30, 7'h12, 7'h08; dp_n=0 only on an_n=6'b111011; each digit held for exactly 4 cycles.
- Strobe held high 10 cycles while data changes 8'h01→8'h02 after capture -> displayed value stays 8'h01.
- Scan order and wrap: run 20 wraps -> an_n cycles 6'h3E, 3D, 3B, 37, 3E…; never zero-hot or two-hot.
- BCD (macro defined): hi=8'd255, lo=8'd7 -> busy high exactly 8 cycles; digits 7, 0, 0, 5, 5, 2 (seg 7'h78, 40, 40, 12, 12, 24).
- BCD overlap: second strobe (hi=8'd10) at busy cycle 3, third strobe (hi=8'd99) at cycle 5 -> pending set; after first result, second conversion runs with hi=99; busy total = 8 + 1 + 8 cycles. Then reset at conversion cycle 4 -> busy=0 at once and display blank.
